dtc_class_vote: RTL and testbench
=================================

Name: dtc_class_vote

Overview:
- Downstream stage for the decision-tree classifiers (dtc_* family, 3-bit class output).
- Accepts one class prediction per valid/ready handshake and histograms predictions over a window of WINDOW samples.
- Resolves the majority class with a sequential scan and presents it on a valid/ready output, giving a temporally smoothed label stream.

Parameters:
- WINDOW, 8: samples per vote window; legal range 1..255.
- CLS_W, 3: class code width; matches classifier outp width.
- NUM_CLS, 8: number of histogram bins; equals 2**CLS_W.
- CNT_W (localparam), $clog2(WINDOW+1): width of the per-class counters and the sample counter.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: in_class is valid.
- in_ready, output, 1: block can accept a sample.
- in_class, input, CLS_W: classifier prediction.
- in_flush, input, 1: close the current partial window early.
- out_valid, output, 1: vote result is valid.
- out_ready, input, 1: consumer accepts the result.
- out_class, output, CLS_W: majority class.
- out_n, output, CNT_W: number of samples in the resolved window.

Behaviour:
- Reset (async assert, sync release): state=ACCUM; all bin counters=0; sample_cnt=0; out_valid=0; out_class=0; out_n=0; scan registers=0.
- States: ACCUM, SCAN, EMIT.
- ACCUM:
  - in_ready=1.
  - Accept (in_valid&in_ready): bin[in_class]++ and sample_cnt++.
  - If the accept makes sample_cnt==WINDOW, go to SCAN next cycle.
  - in_flush with sample_cnt>0 (counting a same-cycle accept first) goes to SCAN.
  - in_flush with sample_cnt==0 and no accept is ignored, with no output.
  - in_flush outside ACCUM is ignored.
- SCAN:
  - in_ready=0.
  - Scan index i runs 0..NUM_CLS-1, one bin per cycle, so the state lasts exactly NUM_CLS cycles.
  - best_cnt and best_cls are initialised to bin[0] and class 0 on entry.
  - A bin replaces best only if its count is strictly greater, so ties resolve to the lowest class index.
  - After bin NUM_CLS-1: load out_class=best_cls and out_n=sample_cnt, assert out_valid, go to EMIT.
- EMIT:
  - in_ready=0.
  - out_valid, out_class and out_n are held stable until out_ready.
  - On the handshake cycle: clear all bins and sample_cnt, drop out_valid next cycle, return to ACCUM.
  - in_ready rises the cycle after the handshake; there is no bypass.
- Latency: the last sample is accepted at cycle t; out_valid=1 from cycle t+NUM_CLS+1.
- Throughput: one window per WINDOW+NUM_CLS+1 cycles minimum.
- Counter safety: no bin can exceed WINDOW, so there is no wrap. sample_cnt never exceeds WINDOW because ACCUM exits at WINDOW.
- Reset mid-SCAN or mid-EMIT: the window is discarded and no partial result is emitted.
- in_class is sampled only on an accept; values on idle cycles have no effect.

Optional Feature:
- Macro: DTC_VOTE_MARGIN_EN.
- Defined:
  - Adds output port out_margin, width CNT_W, with reset value 0.
  - out_margin = best_cnt minus the second-highest bin count, tracked during SCAN.
  - Ties give a margin of 0.
  - out_margin is held with out_class during EMIT.
- Undefined:
  - Port and second-best tracking are absent.
  - All other behaviour is identical.

Decomposition:
- Package dtc_pkg:
  - DTC_CLS_W=3 and DTC_NUM_CLS=8.
  - typedef logic [DTC_CLS_W-1:0] dtc_cls_t.
  - State enum dtc_vote_state_e {ACCUM, SCAN, EMIT}.
- Sub-module dtc_vote_hist:
  - Holds the NUM_CLS counter bank with increment, clear and read-by-index ports.
- dtc_class_vote:
  - Keeps the FSM, the scan/argmax logic and the handshake.

Test Plan:
- WINDOW=8, inputs 3,3,5,3,1,3,5,0 back-to-back -> out_class=3, out_n=8, out_valid exactly NUM_CLS+1 cycles after the 8th accept.
- Tie: inputs 6,2,6,2,6,2,6,2 -> out_class=2 (lowest index wins); with DTC_VOTE_MARGIN_EN, out_margin=0.
- Flush: 3 samples 4,4,1, then in_flush with no valid -> out_class=4, out_n=3. A flush while empty produces no out_valid.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid, out_class and out_n stable; in_ready=0 throughout; samples offered during this time are not accepted.
- Flush together with an accept on the 2nd sample (inputs 7,7) -> out_n=2, out_class=7.
- Assert rst during SCAN -> next cycle out_valid=0 and in_ready=1; a fresh window of 8×class 5 yields out_class=5, out_n=8.

Source files
------------

// File: rtl/dtc_pkg.sv
// Shared types for the dtc_* classifier family: class code width, bin count,
// and the vote-stage FSM states.
package dtc_pkg;

  localparam int DTC_CLS_W   = 3;
  localparam int DTC_NUM_CLS = 8;

  typedef logic [DTC_CLS_W-1:0] dtc_cls_t;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    EMIT  = 2'd2
  } dtc_vote_state_e;

endpackage

// File: rtl/dtc_vote_hist.sv
// Per-class sample counter bank: one increment port, a bulk clear, and a
// combinational read-by-index port used by the argmax scan.
module dtc_vote_hist
  import dtc_pkg::*;
#(
  parameter int NUM_CLS = DTC_NUM_CLS,
  parameter int CLS_W   = DTC_CLS_W,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic [CLS_W-1:0] inc_idx_i,
  input  logic             clr_i,
  input  logic [CLS_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0] rd_cnt_o
);

  logic [NUM_CLS-1:0][CNT_W-1:0] bin_q;

  // Clear and increment never coincide: clear happens only in EMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CLS; i++) begin
        if (clr_i)
          bin_q[i] <= '0;
        else if (inc_i && (inc_idx_i == CLS_W'(i)))
          bin_q[i] <= bin_q[i] + CNT_W'(1);
      end
    end
  end

  assign rd_cnt_o = bin_q[rd_idx_i];

endmodule

// File: rtl/dtc_class_vote.sv
// Windowed majority vote over classifier labels: histogram, sequential argmax
// scan, valid/ready result. DTC_VOTE_MARGIN_EN adds the out_margin port.
module dtc_class_vote
  import dtc_pkg::*;
#(
  parameter int WINDOW  = 8,
  parameter int CLS_W   = DTC_CLS_W,
  parameter int NUM_CLS = DTC_NUM_CLS,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CLS_W-1:0] in_class,
  input  logic             in_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CLS_W-1:0] out_class,
  output logic [CNT_W-1:0] out_n
`ifdef DTC_VOTE_MARGIN_EN
  ,
  output logic [CNT_W-1:0] out_margin
`endif
);

  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLS - 1);
  localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WINDOW);

  dtc_vote_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CLS_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [CLS_W-1:0] best_cls_q, best_cls_d;
  logic             out_valid_q, out_valid_d;
  logic [CLS_W-1:0] out_class_q, out_class_d;
  logic [CNT_W-1:0] out_n_q, out_n_d;
`ifdef DTC_VOTE_MARGIN_EN
  logic [CNT_W-1:0] second_q, second_d;
  logic [CNT_W-1:0] out_margin_q, out_margin_d;
`endif

  logic             hist_inc;
  logic             hist_clr;
  logic [CNT_W-1:0] rd_cnt;

  dtc_vote_hist #(
    .NUM_CLS (NUM_CLS),
    .CLS_W   (CLS_W),
    .CNT_W   (CNT_W)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (hist_inc),
    .inc_idx_i (in_class),
    .clr_i     (hist_clr),
    .rd_idx_i  (idx_q),
    .rd_cnt_o  (rd_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      idx_q       <= '0;
      best_cnt_q  <= '0;
      best_cls_q  <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_n_q     <= '0;
`ifdef DTC_VOTE_MARGIN_EN
      second_q     <= '0;
      out_margin_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      best_cnt_q  <= best_cnt_d;
      best_cls_q  <= best_cls_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_n_q     <= out_n_d;
`ifdef DTC_VOTE_MARGIN_EN
      second_q     <= second_d;
      out_margin_q <= out_margin_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    best_cnt_d  = best_cnt_q;
    best_cls_d  = best_cls_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_n_d     = out_n_q;
`ifdef DTC_VOTE_MARGIN_EN
    second_d     = second_q;
    out_margin_d = out_margin_q;
`endif
    in_ready = 1'b0;
    hist_inc = 1'b0;
    hist_clr = 1'b0;

    unique case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hist_inc = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
        // cnt_d already counts a same-cycle accept, so flush+accept on an
        // empty window still closes it with one sample.
        if ((in_valid && (cnt_d == WIN_CNT)) || (in_flush && (cnt_d != '0))) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end

      SCAN: begin
        idx_d = idx_q + CLS_W'(1);
        if (idx_q == '0) begin
          best_cnt_d = rd_cnt;
          best_cls_d = '0;
`ifdef DTC_VOTE_MARGIN_EN
          second_d   = '0;
`endif
        end else begin
`ifdef DTC_VOTE_MARGIN_EN
          if (rd_cnt > best_cnt_q)
            second_d = best_cnt_q;
          else if (rd_cnt > second_q)
            second_d = rd_cnt;
`endif
          // Strict compare keeps the lowest class on ties.
          if (rd_cnt > best_cnt_q) begin
            best_cnt_d = rd_cnt;
            best_cls_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          state_d     = EMIT;
          out_valid_d = 1'b1;
          out_class_d = best_cls_d;
          out_n_d     = cnt_q;
`ifdef DTC_VOTE_MARGIN_EN
          out_margin_d = best_cnt_d - second_d;
`endif
        end
      end

      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          hist_clr    = 1'b1;
          cnt_d       = '0;
          state_d     = ACCUM;
        end
      end

      default: state_d = ACCUM;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_n     = out_n_q;
`ifdef DTC_VOTE_MARGIN_EN
  assign out_margin = out_margin_q;
`endif

endmodule

// File: tb/tb_dtc_class_vote.sv
// Randomized bench for dtc_class_vote against a window-level vote model.
module tb_dtc_class_vote;
  import dtc_pkg::*;

  localparam int WINDOW  = 8;
  localparam int NUM_CLS = DTC_NUM_CLS;
  localparam int CLS_W   = DTC_CLS_W;
  localparam int CNT_W   = $clog2(WINDOW + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [CLS_W-1:0] in_class;
  logic             in_flush;
  logic             out_valid;
  logic             out_ready;
  logic [CLS_W-1:0] out_class;
  logic [CNT_W-1:0] out_n;
`ifdef DTC_VOTE_MARGIN_EN
  logic [CNT_W-1:0] out_margin;
`endif

  int checks = 0;
  int errors = 0;
  int stim[WINDOW];

  always #5 clk = ~clk;

  dtc_class_vote #(.WINDOW(WINDOW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_flush  (in_flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_n     (out_n)
`ifdef DTC_VOTE_MARGIN_EN
    ,
    .out_margin(out_margin)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Majority over the first n entries of stim; ties go to the lowest class.
  function automatic void vote(input int n, output int cls, output int mrg);
    int cnt[NUM_CLS];
    int second;
    foreach (cnt[c]) cnt[c] = 0;
    for (int i = 0; i < n; i++) cnt[stim[i]]++;
    cls = 0;
    for (int c = 1; c < NUM_CLS; c++) if (cnt[c] > cnt[cls]) cls = c;
    second = 0;
    for (int c = 0; c < NUM_CLS; c++) if (c != cls && cnt[c] > second) second = cnt[c];
    mrg = cnt[cls] - second;
  endfunction

  task automatic junk();
    in_valid = 1'($urandom_range(0, 1));
    in_class = dtc_cls_t'($urandom_range(0, NUM_CLS - 1));
    in_flush = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_out(input string tag, input int ecls, input int en, input int emrg);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_class"}, int'(out_class), ecls);
    chk({tag, "_n"}, int'(out_n), en);
`ifdef DTC_VOTE_MARGIN_EN
    chk({tag, "_margin"}, int'(out_margin), emrg);
`else
    if (emrg < 0) chk({tag, "_margin_neg"}, emrg, 0);
`endif
  endtask

  // fmode: 0 = closes on WINDOW, 1 = flush with last accept, 2 = flush after.
  task automatic run_win(input int n, input int fmode, input int hold);
    int ecls, emrg, lat, gap;
    vote(n, ecls, emrg);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_class = dtc_cls_t'($urandom_range(0, NUM_CLS - 1));
        in_flush = (i == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_class = dtc_cls_t'(stim[i]);
      in_flush = (fmode == 1 && i == n - 1);
      chk("in_ready_acc", int'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    in_flush = 1'b0;
    if (fmode == 2) begin
      in_flush = 1'b1;
      tick();
      in_flush = 1'b0;
    end
    lat = 1;
    while (!out_valid && lat < 64) begin
      chk("in_ready_scan", int'(in_ready), 0);
      junk();
      tick();
      lat++;
    end
    chk("latency", lat, NUM_CLS + 1);
    for (int h = 0; h < hold; h++) begin
      chk_out("hold", ecls, n, emrg);
      chk("in_ready_hold", int'(in_ready), 0);
      junk();
      tick();
    end
    chk_out("hs", ecls, n, emrg);
    in_valid  = 1'b0;
    in_flush  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_drop", int'(out_valid), 0);
    chk("in_ready_back", int'(in_ready), 1);
  endtask

  initial begin
    int seen, n, fmode;
    rst = 1'b1;
    in_valid = 1'b0;
    in_class = '0;
    in_flush = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_class", int'(out_class), 0);
    chk("rst_n", int'(out_n), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    stim = '{3, 3, 5, 3, 1, 3, 5, 0};
    run_win(8, 0, 0);
    stim = '{6, 2, 6, 2, 6, 2, 6, 2};
    run_win(8, 0, 1);
    stim[0] = 4; stim[1] = 4; stim[2] = 1;
    run_win(3, 2, 0);

    // Empty flush must not produce a result.
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    seen = 0;
    for (int i = 0; i < NUM_CLS + 4; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("empty_flush", seen, 0);

    stim = '{1, 7, 7, 2, 7, 0, 7, 4};
    run_win(8, 0, 20);
    stim[0] = 7; stim[1] = 7;
    run_win(2, 1, 0);

    // Reset in the middle of a scan discards the window.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_class = dtc_cls_t'(2);
      in_flush = (i == 2);
      tick();
    end
    in_valid = 1'b0;
    in_flush = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #2;
    chk("midscan_rst_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", int'(out_valid), 0);
    chk("post_rst_in_ready", int'(in_ready), 1);
    for (int i = 0; i < WINDOW; i++) stim[i] = 5;
    run_win(8, 0, 0);

    for (int w = 0; w < 30; w++) begin
      n = $urandom_range(1, WINDOW);
      fmode = (n == WINDOW) ? 0 : $urandom_range(1, 2);
      seen = $urandom_range(0, 1) ? NUM_CLS - 1 : 2;
      for (int i = 0; i < n; i++) stim[i] = $urandom_range(0, seen);
      run_win(n, fmode, $urandom_range(0, 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
